// File: rtl/ram_loader_pkg.sv
// Shared constants and encodings for the boot-time RAM loader.
package ram_loader_pkg;

  localparam int DATA_ADDR_W_DEF = 16;
  localparam int INST_ADDR_W_DEF = 8;

  localparam logic [7:0] CMD_INST_DEF = 8'hA1;
  localparam logic [7:0] CMD_DATA_DEF = 8'hA2;
  localparam logic [7:0] CMD_GO_DEF   = 8'hA3;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_ADDR_H  = 3'd1,
    S_ADDR_L  = 3'd2,
    S_LEN_H   = 3'd3,
    S_LEN_L   = 3'd4,
    S_PAYLOAD = 3'd5,
    S_CKSUM   = 3'd6
  } state_e;

  typedef enum logic {
    TGT_INST = 1'b0,
    TGT_DATA = 1'b1
  } target_e;

endpackage

// File: rtl/ram_loader.sv
// Parses framed load commands from a byte stream, writes instruction/data RAM,
// and holds the CPU in reset until a GO command arrives.
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter int         DATA_ADDR_W = DATA_ADDR_W_DEF,
  parameter int         INST_ADDR_W = INST_ADDR_W_DEF,
  parameter logic [7:0] CMD_INST    = CMD_INST_DEF,
  parameter logic [7:0] CMD_DATA    = CMD_DATA_DEF,
  parameter logic [7:0] CMD_GO      = CMD_GO_DEF
) (
  input  logic                   clk_in,
  input  logic                   reset,
  input  logic [7:0]             in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic                   inst_w,
  output logic [INST_ADDR_W-1:0] addr_inst_ram,
  output logic [7:0]             din_inst_ram,
  output logic                   data_w,
  output logic [DATA_ADDR_W-1:0] addr_data_ram,
  output logic [7:0]             din_data_ram,
  output logic                   cpu_enable,
  output logic                   cpu_reset,
  input  logic                   finish,
  output logic                   busy,
  output logic                   err,
  output logic                   done
);

  state_e      state_q, state_d;
  target_e     target_q;
  logic [15:0] cur_addr_q;
  logic [7:0]  len_hi_q;
  logic [15:0] rem_q;
  logic [7:0]  sum_q;
  logic [15:0] waddr_q;
  logic [7:0]  wdin_q;
  logic        inst_w_q, data_w_q, err_q;
  logic        cpu_enable_q, cpu_reset_q, done_q;

  logic        accept;
  logic        cmd_load;
  logic        cmd_go;

  assign in_ready = !reset;
  assign accept   = in_valid && in_ready;
  assign cmd_load = (in_data == CMD_INST) || (in_data == CMD_DATA);
  assign cmd_go   = (in_data == CMD_GO);

  always_ff @(posedge clk_in) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept) begin
      case (state_q)
        S_IDLE:    if (cmd_load) state_d = S_ADDR_H;
        S_ADDR_H:  state_d = S_ADDR_L;
        S_ADDR_L:  state_d = S_LEN_H;
        S_LEN_H:   state_d = S_LEN_L;
        S_LEN_L:   state_d = ({len_hi_q, in_data} != 16'd0) ? S_PAYLOAD : S_CKSUM;
        S_PAYLOAD: if (rem_q == 16'd1) state_d = S_CKSUM;
        S_CKSUM:   state_d = S_IDLE;
        default:   state_d = S_IDLE;
      endcase
    end
  end

  // Datapath: strobes, err and write address/data are registered one cycle after acceptance.
  always_ff @(posedge clk_in) begin
    if (reset) begin
      target_q     <= TGT_INST;
      cur_addr_q   <= 16'd0;
      len_hi_q     <= 8'd0;
      rem_q        <= 16'd0;
      sum_q        <= 8'd0;
      waddr_q      <= 16'd0;
      wdin_q       <= 8'd0;
      inst_w_q     <= 1'b0;
      data_w_q     <= 1'b0;
      err_q        <= 1'b0;
      cpu_enable_q <= 1'b0;
      cpu_reset_q  <= 1'b1;
      done_q       <= 1'b0;
    end else begin
      inst_w_q <= 1'b0;
      data_w_q <= 1'b0;
      err_q    <= 1'b0;
      if (accept) begin
        case (state_q)
          S_IDLE: begin
            if (cmd_load) begin
              target_q     <= (in_data == CMD_DATA) ? TGT_DATA : TGT_INST;
              cpu_enable_q <= 1'b0;
              cpu_reset_q  <= 1'b1;
              sum_q        <= 8'd0;
            end else if (cmd_go) begin
              cpu_enable_q <= 1'b1;
              cpu_reset_q  <= 1'b0;
            end else begin
              err_q <= 1'b1;
            end
          end
          S_ADDR_H: cur_addr_q[15:8] <= in_data;
          S_ADDR_L: cur_addr_q[7:0]  <= in_data;
          S_LEN_H:  len_hi_q         <= in_data;
          S_LEN_L:  rem_q            <= {len_hi_q, in_data};
          S_PAYLOAD: begin
            if (target_q == TGT_DATA) data_w_q <= 1'b1;
            else                      inst_w_q <= 1'b1;
            waddr_q    <= cur_addr_q;
            wdin_q     <= in_data;
            cur_addr_q <= cur_addr_q + 16'd1;
            sum_q      <= sum_q + in_data;
            rem_q      <= rem_q - 16'd1;
          end
          S_CKSUM:  err_q <= (in_data != sum_q);
          default:  ;
        endcase
      end
      // A new load command wins over a simultaneous finish.
      if (accept && state_q == S_IDLE && cmd_load) done_q <= 1'b0;
      else if (finish && cpu_enable_q)             done_q <= 1'b1;
    end
  end

  assign inst_w        = inst_w_q;
  assign data_w        = data_w_q;
  assign addr_inst_ram = waddr_q[INST_ADDR_W-1:0];
  assign addr_data_ram = waddr_q[DATA_ADDR_W-1:0];
  assign din_inst_ram  = wdin_q;
  assign din_data_ram  = wdin_q;
  assign cpu_enable    = cpu_enable_q;
  assign cpu_reset     = cpu_reset_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;
  assign done          = done_q;

endmodule
